vx_lsu_sequencer: RTL
=====================

VX_LSU_SEQUENCER -- requirements
Module: VX_lsu_sequencer

Interface
REQ-001 SHALL have parameter NT, default 4: number of lanes (threads); legal range 1..32.
REQ-002 SHALL have parameter NW_BITS, default 2: warp-number width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_mem_read  in  3  load type from the execute/memory register; `NO_MEM_READ means no load.
REQ-006 SHALL have port in_mem_write  in  3  store type; `NO_MEM_WRITE means no store.
REQ-007 SHALL have port in_valid  in  NT  active-lane mask.
REQ-008 SHALL have port in_addr  in  NT*32  per-lane address (lane i at bits 32i+31:32i).
REQ-009 SHALL have port in_wdata  in  NT*32  per-lane store data.
REQ-010 SHALL have port in_warp_num  in  NW_BITS  issuing warp.
REQ-011 SHALL have port out_freeze  out  1  holds the execute/memory register and all upstream stages.
REQ-012 SHALL have ports out_dreq_valid 1, out_dreq_addr 32, out_dreq_wdata 32, out_dreq_read 3, out_dreq_write 3 (all out), and in_dreq_ready  in  1: the single-port data-memory request channel.
REQ-013 SHALL have ports in_drsp_valid  in  1 and in_drsp_data  in  32: load-response channel.
REQ-014 SHALL have ports out_ld_data  out  NT*32, out_ld_valid  out  NT, out_done  out  1, out_warp_num  out  NW_BITS, out_err  out  1.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-016 In IDLE, a memory op (read != `NO_MEM_READ or write != `NO_MEM_WRITE) with in_valid != 0 SHALL latch mask, addresses, store data, op type and warp, then go to ISSUE next cycle.
REQ-017 out_freeze SHALL be combinationally 1 in IDLE while a REQ-016 trigger is present, and 1 throughout ISSUE and WAIT; it SHALL be 0 in DONE and otherwise.
REQ-018 Lanes SHALL be served in ascending index order; lanes with a clear mask bit are skipped and consume no cycles.
REQ-019 In ISSUE, out_dreq_valid SHALL be 1 and addr/wdata/read/write SHALL remain stable until the cycle with in_dreq_ready=1.
REQ-020 On accept: a load SHALL go to WAIT; a store SHALL clear the lane bit and go to ISSUE (next lane) or DONE (none left).
REQ-021 In WAIT, in_drsp_valid SHALL write in_drsp_data into out_ld_data for the current lane, set its out_ld_valid bit, then proceed as in REQ-020.
REQ-022 out_done SHALL pulse high for exactly the one DONE cycle; DONE SHALL always return to IDLE without re-sampling inputs.
REQ-023 Zero-wait memory latency SHALL be 2k+2 cycles for a k-lane load and k+2 for a k-lane store, trigger cycle to DONE inclusive.
REQ-024 out_ld_valid SHALL clear when a new operation is latched; out_ld_data SHALL hold until overwritten.
REQ-025 If read and write are both non-none, the load SHALL be performed, the store ignored, and out_err set.
REQ-026 in_drsp_valid outside WAIT SHALL be ignored and SHALL set out_err; out_err is sticky until reset.
REQ-027 A memory op with in_valid == 0 SHALL issue no request and assert no freeze.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, zero all outputs (out_dreq_read = `NO_MEM_READ, out_dreq_write = `NO_MEM_WRITE), and discard any in-flight request or response.
REQ-029 After release, the first operation SHALL behave identically to the first operation after power-up.

Structure
REQ-030 `NO_MEM_READ, `NO_MEM_WRITE, `NT and the state encoding SHALL come from VX_define.
REQ-031 Lane selection SHALL use one sub-module, VX_priority_encoder (NT-bit mask -> lowest set index plus found flag).

Verification
REQ-032 4-lane load, mask 4'b1111, ready=1, response one cycle after each accept -> addresses issued in order 0..3, done on cycle 10, out_ld_valid=4'b1111.
REQ-033 Store, mask 4'b1010 -> exactly two requests (lanes 1, 3), done on cycle 4, freeze low on that cycle.
REQ-034 in_dreq_ready held low 5 cycles on lane 0 -> request fields constant, freeze stays 1.
REQ-035 reset asserted in WAIT -> next edge IDLE, freeze 0, a late in_drsp_valid ignored.
REQ-036 Spurious in_drsp_valid in IDLE, and a read+write op -> out_err=1 and only the load performed.

Source files
------------

// File: rtl/vx_lsu_sequencer_pkg.sv
// Shared definitions for the LSU lane sequencer:
// memory-op sentinels, default lane count and FSM encoding.
package vx_lsu_sequencer_pkg;

  localparam logic [2:0] NO_MEM_READ  = 3'h7;
  localparam logic [2:0] NO_MEM_WRITE = 3'h7;
  localparam int         DEF_NT       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_mem_op(
    input logic [2:0] rd,
    input logic [2:0] wr
  );
    return (rd != NO_MEM_READ) || (wr != NO_MEM_WRITE);
  endfunction

endpackage

// File: rtl/vx_lsu_sequencer_priority_encoder.sv
// Lowest-set-bit finder used to pick the next lane to serve.
// Returns the index and whether any bit was set.
module vx_lsu_sequencer_priority_encoder #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] index,
  output logic          found
);

  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_lsu_sequencer.sv
// Serialises a multi-lane load/store onto a single-port
// data-memory channel, freezing the pipeline meanwhile.
module vx_lsu_sequencer
  import vx_lsu_sequencer_pkg::*;
#(
  parameter int NT      = DEF_NT,
  parameter int NW_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           in_mem_read,
  input  logic [2:0]           in_mem_write,
  input  logic [NT-1:0]        in_valid,
  input  logic [NT*32-1:0]     in_addr,
  input  logic [NT*32-1:0]     in_wdata,
  input  logic [NW_BITS-1:0]   in_warp_num,
  output logic                 out_freeze,
  output logic                 out_dreq_valid,
  output logic [31:0]          out_dreq_addr,
  output logic [31:0]          out_dreq_wdata,
  output logic [2:0]           out_dreq_read,
  output logic [2:0]           out_dreq_write,
  input  logic                 in_dreq_ready,
  input  logic                 in_drsp_valid,
  input  logic [31:0]          in_drsp_data,
  output logic [NT*32-1:0]     out_ld_data,
  output logic [NT-1:0]        out_ld_valid,
  output logic                 out_done,
  output logic [NW_BITS-1:0]   out_warp_num,
  output logic                 out_err
);

  localparam int LW = (NT > 1) ? $clog2(NT) : 1;

  state_t               state;
  state_t               state_nx;
  logic [NT-1:0]        pend;
  logic [NT-1:0]        pend_rest;
  logic [NT*32-1:0]     addr_q;
  logic [NT*32-1:0]     wdata_q;
  logic [NT*32-1:0]     ld_data_q;
  logic [NT-1:0]        ld_valid_q;
  logic [2:0]           rd_q;
  logic [2:0]           wr_q;
  logic [NW_BITS-1:0]   warp_q;
  logic                 err_q;
  logic [LW-1:0]        lane;
  logic                 found;
  logic                 trig;
  logic                 both;
  logic                 is_load;
  logic                 accept;
  logic                 rsp_take;
  logic                 more;

  vx_lsu_sequencer_priority_encoder #(
    .N  (NT),
    .IW (LW)
  ) u_penc (
    .mask  (pend),
    .index (lane),
    .found (found)
  );

  // Gated by reset so nothing is frozen or latched while held in reset.
  assign trig = reset && (state == ST_IDLE)
             && is_mem_op(in_mem_read, in_mem_write)
             && (|in_valid);

  assign both = (in_mem_read != NO_MEM_READ)
             && (in_mem_write != NO_MEM_WRITE);

  assign is_load  = (rd_q != NO_MEM_READ);
  assign accept   = (state == ST_ISSUE) && in_dreq_ready;
  assign rsp_take = (state == ST_WAIT) && in_drsp_valid;

  always_comb begin
    pend_rest       = pend;
    pend_rest[lane] = 1'b0;
  end

  assign more = |pend_rest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (trig) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!found)
          state_nx = ST_DONE;
        else if (in_dreq_ready)
          state_nx = is_load ? ST_WAIT
                   : (more ? ST_ISSUE : ST_DONE);
      end
      ST_WAIT: begin
        if (in_drsp_valid)
          state_nx = more ? ST_ISSUE : ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= '0;
      rd_q       <= NO_MEM_READ;
      wr_q       <= NO_MEM_WRITE;
      warp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (trig) begin
        pend       <= in_valid;
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
        rd_q       <= in_mem_read;
        // A load wins over a simultaneous store.
        wr_q       <= (in_mem_read != NO_MEM_READ)
                    ? NO_MEM_WRITE : in_mem_write;
        warp_q     <= in_warp_num;
        ld_valid_q <= '0;
      end
      if (accept && !is_load) pend <= pend_rest;
      if (rsp_take) begin
        pend                     <= pend_rest;
        ld_data_q[lane*32 +: 32] <= in_drsp_data;
        ld_valid_q[lane]         <= 1'b1;
      end
      if ((trig && both) || (in_drsp_valid && state != ST_WAIT))
        err_q <= 1'b1;
    end
  end

  always_comb begin
    out_dreq_valid = 1'b0;
    out_dreq_addr  = '0;
    out_dreq_wdata = '0;
    out_dreq_read  = NO_MEM_READ;
    out_dreq_write = NO_MEM_WRITE;
    if (state == ST_ISSUE && found) begin
      out_dreq_valid = 1'b1;
      out_dreq_addr  = addr_q[lane*32 +: 32];
      out_dreq_wdata = is_load ? 32'h0 : wdata_q[lane*32 +: 32];
      out_dreq_read  = rd_q;
      out_dreq_write = wr_q;
    end
  end

  assign out_freeze   = trig || (state == ST_ISSUE)
                     || (state == ST_WAIT);
  assign out_done     = (state == ST_DONE);
  assign out_ld_data  = ld_data_q;
  assign out_ld_valid = ld_valid_q;
  assign out_warp_num = warp_q;
  assign out_err      = err_q;

endmodule
